gpio_debounce_irq: RTL and testbench
====================================

# gpio_debounce_irq

Multi-channel, single-clock GPIO input conditioner: synchronises, debounces and edge-detects `C_DWIDTH` input pins, then raises a maskable, sticky interrupt per pin. It replaces the dual-clock, fixed-time debounce port in the GPIO input path. The sample rate comes from an internal prescaler, the debounce threshold is set at run time, and it adds edge-selectable interrupt status with write-one-to-clear.

## Interface
- `C_DWIDTH`, 32: number of pins.
- `C_FREQ_CLK_HZ`, 100000000: `clk` frequency.
- `C_SAMPLE_HZ`, 1000000: sample tick rate. `DIV = C_FREQ_CLK_HZ/C_SAMPLE_HZ`, which must be ≥1.
- `C_CNT_WIDTH`, 16: width of the threshold and per-pin counters.
- `C_RESET_LEVEL`, 0: reset value of the synchroniser and debounced state (same for all pins).

Ports:
- `clk`  in  1  sole clock.
- `areset`  in  1  asynchronous, active-high reset.
- `gpio_i`  in  C_DWIDTH  raw pin inputs, asynchronous to `clk`.
- `debounce_cnt`  in  C_CNT_WIDTH  stable-tick threshold N. A value of 0 is treated as 1.
- `rise_en`  in  C_DWIDTH  per-pin enable for status set on a rising edge.
- `fall_en`  in  C_DWIDTH  per-pin enable for status set on a falling edge.
- `irq_en`  in  C_DWIDTH  per-pin interrupt mask.
- `irq_clr`  in  C_DWIDTH  one-cycle write-one-to-clear pulses for `irq_status`.
- `gpio_db_o`  out  C_DWIDTH  debounced pin state.
- `rise_o`  out  C_DWIDTH  one-cycle rising-edge pulses of `gpio_db_o`.
- `fall_o`  out  C_DWIDTH  one-cycle falling-edge pulses of `gpio_db_o`.
- `irq_status`  out  C_DWIDTH  sticky per-pin event flags.
- `irq`  out  1  registered value of `|(irq_status & irq_en)`.

## Operation
- **Prescaler**
  - Counter `0..DIV-1`. `tick` is high for one `clk` cycle when the counter equals `DIV-1`, then the counter wraps to 0.
  - With `DIV==1`, `tick` is high every cycle.
- **Synchroniser**
  - Two flops per pin (`s1`, `s2`), updated every `clk`.
  - All later logic uses only `s2`.
- **Per-pin debounce** (counter `cnt[i]`, state `db[i]`), evaluated only when `tick` is high:
  - `s2[i]==db[i]`: `cnt[i] <= 0`.
  - `s2[i]!=db[i]` and `cnt[i]+1 >= max(debounce_cnt,1)`: `db[i] <= s2[i]`, `cnt[i] <= 0` (commit).
  - Otherwise: `cnt[i] <= cnt[i]+1`. The counter never wraps, because commit occurs at or before threshold.
  - `debounce_cnt` is compared live. If it is lowered below a running `cnt[i]`, the commit happens at the next mismatching tick.
  - A glitch shorter than N ticks resets `cnt[i]` and leaves `db[i]` unchanged.
- **Edge detect**
  - `db_d` is `db` delayed one cycle.
  - `rise_o = db & ~db_d`, `fall_o = ~db & db_d`, both registered, so each pulse is exactly one cycle.
- **Status**
  - `irq_status[i]` is set on the cycle after `(rise_o[i]&rise_en[i]) | (fall_o[i]&fall_en[i])`.
  - It is cleared by `irq_clr[i]`. If set and clear occur in the same cycle, set wins.
  - Clearing a bit whose status is 0 has no effect.
- **Interrupt**
  - `irq` is registered one cycle after `irq_status`/`irq_en`.
  - Masking (`irq_en`) does not clear status.
- **Reset** (`areset` high, at any time including mid-count)
  - Prescaler, `cnt`, `rise_o`, `fall_o`, `irq_status` and `irq` are all cleared to 0.
  - `s1`, `s2`, `db`, `db_d` and `gpio_db_o` go to `C_RESET_LEVEL`.
  - No edge pulse is generated on reset exit.

## Timing
- With `DIV=1` and threshold N, counting edge 1 as the first `clk` edge that samples a new `gpio_i` level:
  - `s2` is updated at edge 2.
  - `gpio_db_o` changes at edge N+2.
  - `rise_o`/`fall_o` pulse after edge N+3.
  - `irq_status` sets at edge N+4.
  - `irq` asserts at edge N+5.
- General `DIV`: commit occurs on the Nth consecutive mismatching tick after `s2` changes. Latency is between `(N-1)*DIV+3` and `N*DIV+2` clocks to `gpio_db_o`.
- `irq_clr` takes effect at the next edge; `irq` falls one edge later.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Reset values:** `C_RESET_LEVEL=1`, assert `areset` mid-count → `gpio_db_o=4'hF`; `irq_status=0`, `irq=0`; no `fall_o` pulse after release.
- **Clean edge:** `DIV=1`, `C_DWIDTH=4`, `debounce_cnt=5`, `rise_en=1`, `irq_en=1`; `gpio_i[0]` 0→1 held → `gpio_db_o[0]` high at edge 7; one-cycle `rise_o[0]`; `irq_status=4'h1` at edge 9; `irq=1` at edge 10.
- **Glitch rejection:** `debounce_cnt=5`; pulse `gpio_i[1]` high for 4 cycles → `gpio_db_o`, `rise_o`, `fall_o` and `irq_status` unchanged; pulse for 6 cycles → commit then fall-back both occur.
- **Clear and mask:** `fall_en[2]=1`, `irq_en[2]=0`; falling edge → `irq_status[2]=1`, `irq=0`. Set `irq_en[2]=1` → `irq=1` next edge. Pulse `irq_clr[2]` → status 0, `irq` 0 one edge later. Then `irq_clr` coincident with a new set → status stays 1.
- **Prescaler and threshold:** `DIV=10`, `debounce_cnt=3`, toggle held → commit within 23..32 clocks. Repeat with `debounce_cnt=0` → behaves as N=1.
- **Live threshold change:** `debounce_cnt=100`, mismatch held 50 ticks, then set `debounce_cnt=20` → commit on the next tick.

Source files
------------

// File: rtl/gpio_debounce_irq.sv
// Multi-pin GPIO input conditioner: two-flop synchroniser, prescaled run-time
// debounce, registered edge pulses, sticky W1C status and a masked interrupt.
module gpio_debounce_irq #(
    parameter int C_DWIDTH      = 32,
    parameter int C_FREQ_CLK_HZ = 100000000,
    parameter int C_SAMPLE_HZ   = 1000000,
    parameter int C_CNT_WIDTH   = 16,
    parameter bit C_RESET_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [C_DWIDTH-1:0]    gpio_i,
    input  logic [C_CNT_WIDTH-1:0] debounce_cnt,
    input  logic [C_DWIDTH-1:0]    rise_en,
    input  logic [C_DWIDTH-1:0]    fall_en,
    input  logic [C_DWIDTH-1:0]    irq_en,
    input  logic [C_DWIDTH-1:0]    irq_clr,
    output logic [C_DWIDTH-1:0]    gpio_db_o,
    output logic [C_DWIDTH-1:0]    rise_o,
    output logic [C_DWIDTH-1:0]    fall_o,
    output logic [C_DWIDTH-1:0]    irq_status,
    output logic                   irq
);

    localparam int DIV = C_FREQ_CLK_HZ / C_SAMPLE_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW1 = C_CNT_WIDTH + 1;
    localparam logic [PW-1:0]       DIV_M1  = PW'(DIV - 1);
    localparam logic [C_DWIDTH-1:0] RST_VEC = {C_DWIDTH{C_RESET_LEVEL}};

    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick_s;
    logic [CW1-1:0]         thr_s;
    logic [C_DWIDTH-1:0]    s1_q, s1_d, s2_q, s2_d;
    logic [C_DWIDTH-1:0]    db_q, db_d, db_prev_q, db_prev_d;
    logic [C_DWIDTH-1:0]    rise_q, rise_d, fall_q, fall_d;
    logic [C_DWIDTH-1:0]    status_q, status_d;
    logic                   irq_q, irq_d;
    logic [C_CNT_WIDTH-1:0] cnt_q [C_DWIDTH];
    logic [C_CNT_WIDTH-1:0] cnt_d [C_DWIDTH];

    // Prescaler, synchroniser, edge/status/interrupt next-state logic
    always_comb begin
        tick_s = (presc_q == DIV_M1);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        // a zero threshold behaves exactly like a threshold of one
        if (debounce_cnt == '0) begin
            thr_s = CW1'(1);
        end else begin
            thr_s = {1'b0, debounce_cnt};
        end
        s1_d      = gpio_i;
        s2_d      = s1_q;
        db_prev_d = db_q;
        rise_d    = db_q & ~db_prev_q;
        fall_d    = ~db_q & db_prev_q;
        status_d  = ((rise_q & rise_en) | (fall_q & fall_en)) | (status_q & ~irq_clr);
        irq_d     = |(status_q & irq_en);
    end

    // Per-pin debounce counter and committed level, advanced on sample ticks
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < C_DWIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!tick_s) begin
                cnt_d[i] = cnt_q[i];
            end else if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (({1'b0, cnt_q[i]} + CW1'(1)) >= thr_s) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + C_CNT_WIDTH'(1);
            end
        end
    end

    // State registers; level-holding flops reset to the configured pin level
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            presc_q   <= '0;
            s1_q      <= RST_VEC;
            s2_q      <= RST_VEC;
            db_q      <= RST_VEC;
            db_prev_q <= RST_VEC;
            rise_q    <= '0;
            fall_q    <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < C_DWIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            status_q  <= status_d;
            irq_q     <= irq_d;
            for (int i = 0; i < C_DWIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_db_o  = db_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign irq_status = status_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Directed bench: dut_a runs at DIV=1/reset level 0, dut_b at DIV=10/reset level 1.
module tb_gpio_debounce_irq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, b_rst;
    logic [3:0]  a_gpio, a_rise_en, a_fall_en, a_irq_en, a_clr;
    logic [3:0]  a_db, a_rise, a_fall, a_status;
    logic [15:0] a_dc;
    logic        a_irq;
    logic [3:0]  b_gpio, b_rise_en, b_fall_en, b_irq_en, b_clr;
    logic [3:0]  b_db, b_rise, b_fall, b_status;
    logic [15:0] b_dc;
    logic        b_irq;

    gpio_debounce_irq #(.C_DWIDTH(4), .C_FREQ_CLK_HZ(1), .C_SAMPLE_HZ(1),
                        .C_CNT_WIDTH(16), .C_RESET_LEVEL(1'b0)) dut_a (
        .clk(clk), .areset(a_rst), .gpio_i(a_gpio), .debounce_cnt(a_dc),
        .rise_en(a_rise_en), .fall_en(a_fall_en), .irq_en(a_irq_en), .irq_clr(a_clr),
        .gpio_db_o(a_db), .rise_o(a_rise), .fall_o(a_fall), .irq_status(a_status), .irq(a_irq));

    gpio_debounce_irq #(.C_DWIDTH(4), .C_FREQ_CLK_HZ(10), .C_SAMPLE_HZ(1),
                        .C_CNT_WIDTH(16), .C_RESET_LEVEL(1'b1)) dut_b (
        .clk(clk), .areset(b_rst), .gpio_i(b_gpio), .debounce_cnt(b_dc),
        .rise_en(b_rise_en), .fall_en(b_fall_en), .irq_en(b_irq_en), .irq_clr(b_clr),
        .gpio_db_o(b_db), .rise_o(b_rise), .fall_o(b_fall), .irq_status(b_status), .irq(b_irq));

    typedef struct {
        logic [3:0] gpio;
        logic [3:0] clr;
        logic [3:0] db;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] st;
        logic       irq;
    } vec_t;

    vec_t tbl [13];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_r, n_f;
        logic [3:0] seen_db, seen_edge, seen_st;
        logic found;

        // Clean-edge table: row k drives before edge k+1, expects after it.
        for (int i = 0; i < 6; i++) tbl[i] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[6]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[7]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[8]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0};
        tbl[9]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[10] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[11] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[12] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};

        a_rst = 1'b1; a_gpio = 4'h0; a_dc = 16'd5; a_clr = 4'h0;
        a_rise_en = 4'h1; a_fall_en = 4'h0; a_irq_en = 4'h1;
        b_rst = 1'b1; b_gpio = 4'hF; b_dc = 16'd3; b_clr = 4'h0;
        b_rise_en = 4'hF; b_fall_en = 4'hF; b_irq_en = 4'hF;
        repeat (3) step();
        a_rst = 1'b0; b_rst = 1'b0;
        step();
        check("rst_a db", a_db, 4'h0);
        check("rst_a status", a_status, 4'h0);
        check("rst_a irq", {3'b0, a_irq}, 4'h0);
        check("rst_b db", b_db, 4'hF);

        // Reset level 1, reset asserted in the middle of a running count
        b_gpio = 4'hE;
        repeat (15) step();
        b_rst = 1'b1;
        #1;
        check("midrst db", b_db, 4'hF);
        check("midrst status", b_status, 4'h0);
        check("midrst irq", {3'b0, b_irq}, 4'h0);
        b_gpio = 4'hF;
        step();
        b_rst = 1'b0;
        seen_edge = 4'h0; seen_st = 4'h0; seen_db = 4'hF;
        for (int i = 0; i < 30; i++) begin
            step();
            seen_edge = seen_edge | b_fall | b_rise;
            seen_st   = seen_st | b_status | {3'b0, b_irq};
            seen_db   = seen_db & b_db;
        end
        check("rstexit no edge", seen_edge, 4'h0);
        check("rstexit no status", seen_st, 4'h0);
        check("rstexit db", seen_db, 4'hF);

        // Prescaler DIV=10, threshold 3
        b_gpio = 4'hE;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (b_db[0] == 1'b0) begin
                lat = k;
                break;
            end
        end
        check_range("presc N=3 latency", lat, 23, 32);
        // Threshold 0 behaves as 1
        b_dc = 16'd0;
        b_gpio = 4'hF;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (b_db[0] == 1'b1) begin
                lat = k;
                break;
            end
        end
        check_range("presc N=0 latency", lat, 3, 12);

        // Clean edge on pin 0, then W1C
        for (int i = 0; i < 13; i++) begin
            a_gpio = tbl[i].gpio;
            a_clr  = tbl[i].clr;
            step();
            check($sformatf("v%0d db", i), a_db, tbl[i].db);
            check($sformatf("v%0d rise", i), a_rise, tbl[i].rise);
            check($sformatf("v%0d fall", i), a_fall, tbl[i].fall);
            check($sformatf("v%0d status", i), a_status, tbl[i].st);
            check($sformatf("v%0d irq", i), {3'b0, a_irq}, {3'b0, tbl[i].irq});
        end
        a_clr = 4'h0;

        // Glitch of 4 cycles on pin 1 must be rejected
        seen_db = 4'h0; seen_edge = 4'h0; seen_st = 4'h0;
        a_gpio = 4'h3;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) a_gpio = 4'h1;
            step();
            seen_db   = seen_db | (a_db & 4'h2);
            seen_edge = seen_edge | a_rise | a_fall;
            seen_st   = seen_st | a_status;
        end
        check("glitch4 db", seen_db, 4'h0);
        check("glitch4 edges", seen_edge, 4'h0);
        check("glitch4 status", seen_st, 4'h0);

        // 6-cycle pulse commits then falls back
        n_r = 0; n_f = 0;
        a_gpio = 4'h3;
        for (int i = 0; i < 30; i++) begin
            if (i == 6) a_gpio = 4'h1;
            step();
            if (a_rise[1]) n_r++;
            if (a_fall[1]) n_f++;
        end
        check("pulse6 rise count", 4'(n_r), 4'h1);
        check("pulse6 fall count", 4'(n_f), 4'h1);
        check("pulse6 db", a_db, 4'h1);
        check("pulse6 status", a_status, 4'h0);

        // Clear and mask on pin 2
        a_fall_en = 4'h4;
        a_gpio = 4'h5;
        repeat (10) step();
        check("pin2 high db", a_db, 4'h5);
        check("pin2 high status", a_status, 4'h0);
        a_gpio = 4'h1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_status[2]) begin
                found = 1'b1;
                break;
            end
        end
        check("fall status seen", {3'b0, found}, 4'h1);
        check("masked status", a_status, 4'h4);
        check("masked irq", {3'b0, a_irq}, 4'h0);
        a_irq_en = 4'h5;
        step();
        check("unmask irq", {3'b0, a_irq}, 4'h1);
        a_clr = 4'h4;
        step();
        a_clr = 4'h0;
        check("clr status", a_status, 4'h0);
        check("clr irq lag", {3'b0, a_irq}, 4'h1);
        step();
        check("clr irq low", {3'b0, a_irq}, 4'h0);

        // Clear coincident with a new set: set wins
        a_gpio = 4'h5;
        repeat (10) step();
        a_gpio = 4'h1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_fall[2]) begin
                found = 1'b1;
                break;
            end
        end
        check("fall2 pulse seen", {3'b0, found}, 4'h1);
        a_clr = 4'h4;
        step();
        a_clr = 4'h0;
        check("set wins status", a_status, 4'h4);

        // Live threshold change on pin 3
        a_dc = 16'd100;
        a_gpio = 4'h9;
        repeat (52) step();
        check("live before", a_db, 4'h1);
        a_dc = 16'd20;
        step();
        check("live commit", a_db, 4'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
